hazard_detection_unit: RTL and testbench
========================================

# hazard_detection_unit

Stall and flush controller for the 5-stage MIPS pipeline. Forwarding resolves data hazards by bypassing results. This block handles the hazards that bypassing cannot fix: load-use, and branch/jr operands needed in ID. It holds PC and IF/ID, injects a bubble into ID/EX, and flushes IF/ID on taken control transfers. It sits beside the ID stage and contains a small stall FSM plus saturating stall and flush statistics counters.

## Interface
- CNT_WIDTH, 16, width of each statistics counter
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- reg_rs_IFID_i  input  5  rs field of the instruction in ID
- reg_rt_IFID_i  input  5  rt field of the instruction in ID
- uses_rt_ID_i  input  1  ID instruction reads rt as a source (R-type, beq/bne, sw)
- is_branch_ID_i  input  1  ID instruction is beq/bne (compared in ID)
- is_jr_ID_i  input  1  ID instruction is jr (reads rs in ID)
- branch_taken_ID_i  input  1  ID branch resolved taken
- jump_ID_i  input  1  ID instruction is j/jal/jr
- ctl_mem_read_IDEX_i  input  1  EX instruction is a load
- ctl_reg_write_IDEX_i  input  1  EX instruction writes a register
- reg_dest_IDEX_i  input  5  EX destination register
- ctl_mem_read_EXMEM_i  input  1  MEM instruction is a load
- reg_dest_EXMEM_i  input  5  MEM destination register
- clear_counters_i  input  1  synchronous clear of both counters
- pc_write_o  output  1  PC update enable
- ifid_write_o  output  1  IF/ID update enable
- idex_bubble_o  output  1  zero ID/EX control fields this cycle
- ifid_flush_o  output  1  clear IF/ID this cycle
- stall_cycles_o  output  CNT_WIDTH  saturating count of stall cycles
- flush_count_o  output  CNT_WIDTH  saturating count of flushes

## Operation
- Match terms. rsX = (dest == rs). rtX = uses_rt_ID_i && (dest == rt). Both are valid only when dest != 0.
- ctrl_ID = is_branch_ID_i | is_jr_ID_i. For jr, only rsX applies.
- Hazard conditions, evaluated only in RUN:
  - LU_ALU: ctl_mem_read_IDEX_i, match on reg_dest_IDEX_i, !ctrl_ID. Needs 1 stall.
  - LU_CTRL: ctl_mem_read_IDEX_i, match on reg_dest_IDEX_i, ctrl_ID. Needs 2 stalls.
  - ALU_CTRL: ctl_reg_write_IDEX_i && !ctl_mem_read_IDEX_i, match on reg_dest_IDEX_i, ctrl_ID. Needs 1 stall.
  - LD_CTRL: ctl_mem_read_EXMEM_i, match on reg_dest_EXMEM_i, ctrl_ID. Needs 1 stall.
- stall = any hazard condition in RUN, or state == STALL_1.
  - When stall=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - When stall=0: pc_write_o=1, ifid_write_o=1, idex_bubble_o=0.
- Flush: ifid_flush_o = !stall && (branch_taken_ID_i | jump_ID_i). Stall has priority, so a branch is never acted on with stale operands.
- FSM states:
  - RUN: on LU_CTRL go to STALL_1; otherwise stay in RUN. Single-stall hazards stall combinationally and remain in RUN.
  - STALL_1: unconditional stall, then return to RUN. Hazard inputs are ignored in this state.
- Counters:
  - stall_cycles_o increments in every cycle with stall=1.
  - flush_count_o increments in every cycle with ifid_flush_o=1.
  - Both saturate at all-ones.
  - clear_counters_i clears both and takes priority over an increment in the same cycle.

## Timing
- Stall and flush outputs are combinational from the current state and inputs, valid in the same cycle as the hazard.
- FSM state and counters are registered.
- Reset:
  - State returns to RUN and both counters to 0 on the clock edge where reset=1.
  - While reset=1, outputs are forced to pc_write_o=1, ifid_write_o=1, idex_bubble_o=0, ifid_flush_o=0.
  - Reset during STALL_1 aborts the stall, and there is no stall after reset deasserts.
- LU_CTRL stall profile: 2 stall cycles total, the detection cycle plus STALL_1, then the branch resolves in the 3rd cycle.
- Counter latency: count is visible 1 cycle after the event.
- Simultaneous hazard and taken branch: stall is applied and flush is suppressed, and the flush happens once the stall releases.
- Destination register 0 never causes a stall.

## Structure
- mips_pipeline_pkg holds:
  - the FSM state type, 1 bit with RUN=0 and STALL_1=1
  - the reg-zero constant
  - the hazard-type encoding (NONE, LU_ALU, LU_CTRL, ALU_CTRL, LD_CTRL), used for debug visibility
- Sub-module sat_counter (parameter WIDTH; ports clk, reset, clr, inc, count) is instantiated twice.

## Test plan
- lw $t0 in EX (dest 8), add in ID with rs=8 → exactly 1 cycle of pc_write_o=0, idex_bubble_o=1; stall_cycles_o=1.
- lw dest 8 in EX, beq rs=8 in ID → 2 consecutive stall cycles (FSM enters STALL_1), then beq with branch_taken=1 → ifid_flush_o=1 in the 3rd cycle; flush_count_o=1.
- add dest 9 in EX (reg_write=1, mem_read=0), jr rs=9 in ID → 1 stall; same pattern with dest=0 → no stall.
- sw in ID with rt=8 and uses_rt=1 behind lw dest 8 → stall; same pattern with uses_rt=0 → no stall.
- Assert reset in STALL_1 → next cycle state is RUN, outputs at non-stall defaults, counters 0.
- Force 2^CNT_WIDTH+3 stall cycles → stall_cycles_o holds all-ones; clear_counters_i together with a stall → reads 0.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Shared types and constants for the MIPS pipeline hazard detection slice.
package mips_pipeline_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    STALL_1 = 1'b1
  } hdu_state_e;

  // Classified hazard in the current cycle, kept as a named signal for debug.
  typedef enum logic [2:0] {
    NONE     = 3'd0,
    LU_ALU   = 3'd1,
    LU_CTRL  = 3'd2,
    ALU_CTRL = 3'd3,
    LD_CTRL  = 3'd4
  } hazard_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register match that never fires on $zero.
  function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
    return (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Signal bundle between the ID stage pipeline logic and the hazard detection unit.
interface hazard_detection_unit_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic [4:0]           reg_rs_IFID_i;
  logic [4:0]           reg_rt_IFID_i;
  logic                 uses_rt_ID_i;
  logic                 is_branch_ID_i;
  logic                 is_jr_ID_i;
  logic                 branch_taken_ID_i;
  logic                 jump_ID_i;
  logic                 ctl_mem_read_IDEX_i;
  logic                 ctl_reg_write_IDEX_i;
  logic [4:0]           reg_dest_IDEX_i;
  logic                 ctl_mem_read_EXMEM_i;
  logic [4:0]           reg_dest_EXMEM_i;
  logic                 clear_counters_i;
  logic                 pc_write_o;
  logic                 ifid_write_o;
  logic                 idex_bubble_o;
  logic                 ifid_flush_o;
  logic [CNT_WIDTH-1:0] stall_cycles_o;
  logic [CNT_WIDTH-1:0] flush_count_o;

  modport master (
    output reg_rs_IFID_i, reg_rt_IFID_i, uses_rt_ID_i, is_branch_ID_i, is_jr_ID_i,
           branch_taken_ID_i, jump_ID_i, ctl_mem_read_IDEX_i, ctl_reg_write_IDEX_i,
           reg_dest_IDEX_i, ctl_mem_read_EXMEM_i, reg_dest_EXMEM_i, clear_counters_i,
    input  pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o,
           stall_cycles_o, flush_count_o
  );

  modport slave (
    input  reg_rs_IFID_i, reg_rt_IFID_i, uses_rt_ID_i, is_branch_ID_i, is_jr_ID_i,
           branch_taken_ID_i, jump_ID_i, ctl_mem_read_IDEX_i, ctl_reg_write_IDEX_i,
           reg_dest_IDEX_i, ctl_mem_read_EXMEM_i, reg_dest_EXMEM_i, clear_counters_i,
    output pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o,
           stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear beats increment).
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for hazards that bypassing cannot resolve (load-use,
// branch/jr operands consumed in ID), with stall and flush statistics.
module hazard_detection_unit
  import mips_pipeline_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_detection_unit_if.slave  hz
);

  hdu_state_e state, state_nxt;
  hazard_e    hazard;
  logic       ctrl_id;
  logic       match_ex, match_mem;
  logic       stall, flush;
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

  // jr only reads rs, so an rt match is discarded for it.
  assign ctrl_id   = hz.is_branch_ID_i | hz.is_jr_ID_i;
  assign match_ex  = reg_match(hz.reg_dest_IDEX_i, hz.reg_rs_IFID_i)
                   | (hz.uses_rt_ID_i && !hz.is_jr_ID_i
                      && reg_match(hz.reg_dest_IDEX_i, hz.reg_rt_IFID_i));
  assign match_mem = reg_match(hz.reg_dest_EXMEM_i, hz.reg_rs_IFID_i)
                   | (hz.uses_rt_ID_i && !hz.is_jr_ID_i
                      && reg_match(hz.reg_dest_EXMEM_i, hz.reg_rt_IFID_i));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    hazard    = NONE;
    state_nxt = RUN;
    if (state == RUN) begin
      if (hz.ctl_mem_read_IDEX_i && match_ex && ctrl_id) begin
        hazard = LU_CTRL;
      end else if (hz.ctl_mem_read_IDEX_i && match_ex) begin
        hazard = LU_ALU;
      end else if (hz.ctl_reg_write_IDEX_i && !hz.ctl_mem_read_IDEX_i && match_ex && ctrl_id) begin
        hazard = ALU_CTRL;
      end else if (hz.ctl_mem_read_EXMEM_i && match_mem && ctrl_id) begin
        hazard = LD_CTRL;
      end
      if (hazard == LU_CTRL) begin
        state_nxt = STALL_1;
      end
    end
  end

  // Reset masks outputs in the same cycle, so a pending STALL_1 never shows.
  assign stall = !reset && ((hazard != NONE) || (state == STALL_1));
  assign flush = !reset && !stall && (hz.branch_taken_ID_i || hz.jump_ID_i);

  assign hz.pc_write_o    = !stall;
  assign hz.ifid_write_o  = !stall;
  assign hz.idex_bubble_o = stall;
  assign hz.ifid_flush_o  = flush;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hz.clear_counters_i),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hz.clear_counters_i),
    .inc   (flush),
    .count (flush_cnt)
  );

  assign hz.stall_cycles_o = stall_cnt;
  assign hz.flush_count_o  = flush_cnt;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit using a narrow counter width.
module tb_hazard_detection_unit;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] CMAX = '1;

  logic clk;
  logic reset;

  hazard_detection_unit_if #(.CNT_WIDTH(W)) hz ();

  hazard_detection_unit #(.CNT_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_branch;
    logic       is_jr;
    logic       taken;
    logic       jump;
    logic       mr_ex;
    logic       rw_ex;
    logic [4:0] dest_ex;
    logic       mr_mem;
    logic [4:0] dest_mem;
  } in_t;

  typedef struct {
    string      tag;
    logic       stall;
    logic       flush;
    logic [W-1:0] sc;
    logic [W-1:0] fc;
  } exp_t;

  exp_t sb[$];
  in_t  cur;
  logic rst_in, clr_in;
  logic [W-1:0] m_sc, m_fc;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic e_stall, input logic e_flush);
    exp_t e;
    hz.reg_rs_IFID_i        = cur.rs;
    hz.reg_rt_IFID_i        = cur.rt;
    hz.uses_rt_ID_i         = cur.uses_rt;
    hz.is_branch_ID_i       = cur.is_branch;
    hz.is_jr_ID_i           = cur.is_jr;
    hz.branch_taken_ID_i    = cur.taken;
    hz.jump_ID_i            = cur.jump;
    hz.ctl_mem_read_IDEX_i  = cur.mr_ex;
    hz.ctl_reg_write_IDEX_i = cur.rw_ex;
    hz.reg_dest_IDEX_i      = cur.dest_ex;
    hz.ctl_mem_read_EXMEM_i = cur.mr_mem;
    hz.reg_dest_EXMEM_i     = cur.dest_mem;
    hz.clear_counters_i     = clr_in;
    reset                   = rst_in;
    e.tag = tag; e.stall = e_stall; e.flush = e_flush; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_pc_write"},   32'(hz.pc_write_o),     32'(!e.stall));
      check({e.tag, "_ifid_write"}, 32'(hz.ifid_write_o),   32'(!e.stall));
      check({e.tag, "_bubble"},     32'(hz.idex_bubble_o),  32'(e.stall));
      check({e.tag, "_flush"},      32'(hz.ifid_flush_o),   32'(e.flush));
      check({e.tag, "_stall_cnt"},  32'(hz.stall_cycles_o), 32'(e.sc));
      check({e.tag, "_flush_cnt"},  32'(hz.flush_count_o),  32'(e.fc));
    end
    @(posedge clk);
    if (rst_in || clr_in) begin
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (e.stall && m_sc != CMAX) m_sc = m_sc + 1'b1;
      if (e.flush && m_fc != CMAX) m_fc = m_fc + 1'b1;
    end
    #1;
  endtask

  function automatic in_t lu_alu();
    in_t v = '0;
    v.mr_ex = 1'b1; v.rw_ex = 1'b1; v.dest_ex = 5'd8; v.rs = 5'd8; v.rt = 5'd3; v.uses_rt = 1'b1;
    return v;
  endfunction

  function automatic in_t lu_ctrl();
    in_t v = '0;
    v.mr_ex = 1'b1; v.rw_ex = 1'b1; v.dest_ex = 5'd8; v.rs = 5'd8; v.rt = 5'd4;
    v.uses_rt = 1'b1; v.is_branch = 1'b1;
    return v;
  endfunction

  initial begin
    cur = '0; rst_in = 1'b1; clr_in = 1'b0;
    step("init0", 1'b0, 1'b0);
    sb.delete();
    n_checks = 0; n_fail = 0;
    rst_in = 1'b1; clr_in = 1'b0; m_sc = '0; m_fc = '0;
    cur = lu_alu(); cur.taken = 1'b1;
    step("reset_masks", 1'b0, 1'b0);
    rst_in = 1'b0;

    cur = '0;              step("idle", 1'b0, 1'b0);
    cur = lu_alu();        step("lu_alu", 1'b1, 1'b0);
    cur = '0;              step("lu_alu_release", 1'b0, 1'b0);

    cur = lu_ctrl();       step("lu_ctrl_detect", 1'b1, 1'b0);
    cur = lu_ctrl(); cur.taken = 1'b1;
                           step("lu_ctrl_stall1", 1'b1, 1'b0);
    cur = '0; cur.is_branch = 1'b1; cur.rs = 5'd8; cur.taken = 1'b1;
                           step("lu_ctrl_resolve", 1'b0, 1'b1);
    cur = '0;              step("after_branch", 1'b0, 1'b0);

    cur = '0; cur.mr_mem = 1'b1; cur.dest_mem = 5'd8; cur.is_branch = 1'b1;
    cur.rt = 5'd8; cur.uses_rt = 1'b1; cur.taken = 1'b1;
                           step("ld_ctrl", 1'b1, 1'b0);
    cur.mr_mem = 1'b0;     step("ld_ctrl_resolve", 1'b0, 1'b1);

    cur = '0; cur.rw_ex = 1'b1; cur.dest_ex = 5'd9; cur.is_jr = 1'b1; cur.rs = 5'd9; cur.jump = 1'b1;
                           step("alu_jr", 1'b1, 1'b0);
    cur.rw_ex = 1'b0;      step("alu_jr_release", 1'b0, 1'b1);
    cur = '0; cur.rw_ex = 1'b1; cur.dest_ex = 5'd0; cur.is_jr = 1'b1; cur.rs = 5'd0; cur.jump = 1'b1;
                           step("alu_jr_r0", 1'b0, 1'b1);
    cur = '0; cur.rw_ex = 1'b1; cur.dest_ex = 5'd9; cur.is_jr = 1'b1; cur.rs = 5'd3;
    cur.rt = 5'd9; cur.uses_rt = 1'b1; cur.jump = 1'b1;
                           step("jr_rt_ignored", 1'b0, 1'b1);
    cur = '0; cur.rw_ex = 1'b1; cur.dest_ex = 5'd5; cur.rs = 5'd5;
                           step("alu_alu_fwd", 1'b0, 1'b0);
    cur = '0; cur.mr_ex = 1'b1; cur.dest_ex = 5'd0; cur.rs = 5'd0;
                           step("lu_r0", 1'b0, 1'b0);

    cur = '0; cur.mr_ex = 1'b1; cur.dest_ex = 5'd8; cur.rs = 5'd2; cur.rt = 5'd8; cur.uses_rt = 1'b1;
                           step("sw_rt", 1'b1, 1'b0);
    cur.uses_rt = 1'b0;    step("sw_rt_unused", 1'b0, 1'b0);

    cur = lu_ctrl();       step("rst_pre", 1'b1, 1'b0);
    rst_in = 1'b1;         step("rst_in_stall1", 1'b0, 1'b0);
    rst_in = 1'b0; cur = '0;
                           step("rst_after", 1'b0, 1'b0);

    for (int i = 0; i < (1 << W) + 3; i++) begin
      cur = lu_alu();      step("sat", 1'b1, 1'b0);
    end
    cur = '0;              step("sat_hold", 1'b0, 1'b0);
    cur = lu_alu(); clr_in = 1'b1;
                           step("clr_with_stall", 1'b1, 1'b0);
    clr_in = 1'b0; cur = '0;
                           step("clr_after", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
